// File: rtl/pc_stack_unit.sv
// Program counter plus LIFO return-address stack feeding the control unit.
// Calls push pc_addr+1; returns pop into the registered stack_addr.
module pc_stack_unit #(
  parameter int AW           = 11,
  parameter int DEPTH        = 16,
  parameter int RESET_VECTOR = 0,
  localparam int IW          = $clog2(DEPTH),
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ldpc,
  input  logic          selpc,
  input  logic [AW-1:0] naddress,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          clr_err,
  output logic [AW-1:0] pc_addr,
  output logic [AW-1:0] stack_addr,
  output logic [LW-1:0] stack_level,
  output logic          stack_empty,
  output logic          stack_full,
  output logic          stack_ovf,
  output logic          stack_unf
);

  // wr_en/rd_en are single-cycle commands with no back-pressure: the unit
  // always accepts them; a refused push/pop is reported via the sticky flags.

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] stack_addr_q, stack_addr_d;
  logic [LW-1:0] sp_q, sp_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] mem_q [DEPTH];

  logic [AW-1:0] push_val;
  logic          empty, full;
  logic          do_push, ovf_set;
  logic          pop_req, do_pop, unf_set;
  logic [IW-1:0] wr_idx, rd_idx;

  assign push_val = pc_q + AW'(1);
  assign empty    = (sp_q == '0);
  assign full     = (sp_q == LW'(DEPTH));
  assign wr_idx   = sp_q[IW-1:0];
  assign rd_idx   = IW'(sp_q - LW'(1));

  always_comb begin
    do_push      = wr_en && !full;
    ovf_set      = wr_en && full;
    // A simultaneous push wins; the pop side is dropped entirely.
    pop_req      = rd_en && !wr_en;
    do_pop       = pop_req && !empty;
    unf_set      = pop_req && empty;

    pc_d         = pc_q;
    sp_d         = sp_q;
    stack_addr_d = stack_addr_q;

    if (ldpc) begin
      pc_d = selpc ? naddress : push_val;
    end

    if (do_push) begin
      sp_d = sp_q + LW'(1);
    end else if (do_pop) begin
      sp_d = sp_q - LW'(1);
    end

    if (do_pop) begin
      stack_addr_d = mem_q[rd_idx];
    end else if (unf_set) begin
      stack_addr_d = '0;
    end

    // Set beats clear when both happen in the same cycle.
    ovf_d = ovf_set || (ovf_q && !clr_err);
    unf_d = unf_set || (unf_q && !clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= AW'(RESET_VECTOR);
      stack_addr_q <= '0;
      sp_q         <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      stack_addr_q <= stack_addr_d;
      sp_q         <= sp_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  // Storage is deliberately unreset; only sp decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_idx] <= push_val;
    end
  end

  assign pc_addr     = pc_q;
  assign stack_addr  = stack_addr_q;
  assign stack_level = sp_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed test-plan sequences plus
// random traffic, compared against a behavioural model through an expected queue.
module tb_pc_stack_unit;

  localparam int AW    = 11;
  localparam int DEPTH = 16;
  localparam int LW    = 5;
  localparam int W     = AW + AW + LW + 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ldpc, selpc, wr_en, rd_en, clr_err;
  logic [AW-1:0] naddress;
  logic [AW-1:0] pc_addr, stack_addr;
  logic [LW-1:0] stack_level;
  logic          stack_empty, stack_full, stack_ovf, stack_unf;

  pc_stack_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_VECTOR(0)) dut (
    .clk(clk), .rst(rst), .ldpc(ldpc), .selpc(selpc), .naddress(naddress),
    .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .pc_addr(pc_addr), .stack_addr(stack_addr), .stack_level(stack_level),
    .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // behavioural model
  logic [W-1:0]  exp_q[$];
  int            m_pc, m_sa, m_sp;
  bit            m_ovf, m_unf;
  int            m_mem[DEPTH];

  task automatic model_reset();
    m_pc = 0; m_sa = 0; m_sp = 0; m_ovf = 0; m_unf = 0;
  endtask

  function automatic logic [W-1:0] model_outputs();
    return {AW'(m_pc), AW'(m_sa), LW'(m_sp), (m_sp == 0), (m_sp == DEPTH), m_ovf, m_unf};
  endfunction

  task automatic model_step(input bit l, s, input int na, input bit w, r, c);
    int  ret_addr;
    bit  oset, uset;
    ret_addr = (m_pc + 1) % 2048;
    oset = 0; uset = 0;
    if (w) begin
      if (m_sp < DEPTH) begin m_mem[m_sp] = ret_addr; m_sp++; end
      else oset = 1;
    end else if (r) begin
      if (m_sp > 0) begin m_sp--; m_sa = m_mem[m_sp]; end
      else begin m_sa = 0; uset = 1; end
    end
    m_ovf = oset | (m_ovf & !c);
    m_unf = uset | (m_unf & !c);
    if (l) m_pc = s ? na : ret_addr;
  endtask

  // scoreboard: pop one expectation and compare every output field
  task automatic compare_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_nonempty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("pc_addr",     32'(pc_addr),     32'(e[W-1 -: AW]));
    check("stack_addr",  32'(stack_addr),  32'(e[W-AW-1 -: AW]));
    check("stack_level", 32'(stack_level), 32'(e[LW+3 -: LW]));
    check("stack_empty", 32'(stack_empty), 32'(e[3]));
    check("stack_full",  32'(stack_full),  32'(e[2]));
    check("stack_ovf",   32'(stack_ovf),   32'(e[1]));
    check("stack_unf",   32'(stack_unf),   32'(e[0]));
  endtask

  // driver: one clock of commands, expectation queued at drive time
  task automatic step(input bit l, s, input logic [AW-1:0] na, input bit w, r, c);
    @(negedge clk);
    ldpc = l; selpc = s; naddress = na; wr_en = w; rd_en = r; clr_err = c;
    model_step(l, s, int'(na), w, r, c);
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle_inputs();
    ldpc = 0; selpc = 0; naddress = '0; wr_en = 0; rd_en = 0; clr_err = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pc",    32'(pc_addr), 0);
    check("rst_empty", 32'(stack_empty), 1);
    check("rst_level", 32'(stack_level), 0);
    check("rst_full",  32'(stack_full), 0);
    check("rst_flags", {30'b0, stack_ovf, stack_unf}, 0);
    check("rst_sa",    32'(stack_addr), 0);
    rst = 1'b0;

    // sequential increment and hold
    repeat (3) step(1, 0, '0, 0, 0, 0);
    check("pc_inc3", 32'(pc_addr), 3);
    step(0, 0, 11'h555, 0, 0, 0);
    check("pc_hold", 32'(pc_addr), 3);

    // wrap and jump
    step(1, 1, 11'h7FF, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    check("pc_wrap", 32'(pc_addr), 0);
    step(1, 1, 11'h123, 0, 0, 0);
    check("pc_jump", 32'(pc_addr), 32'h123);

    // call / return
    step(1, 1, 11'h010, 0, 0, 0);
    step(1, 1, 11'h200, 1, 0, 0);
    check("call_pc",  32'(pc_addr), 32'h200);
    check("call_lvl", 32'(stack_level), 1);
    step(0, 0, '0, 0, 1, 0);
    check("ret_sa",  32'(stack_addr), 32'h011);
    check("ret_lvl", 32'(stack_level), 0);
    step(1, 1, AW'(m_sa), 0, 0, 0);
    check("ret_pc", 32'(pc_addr), 32'h011);

    // nested fill, overflow, drain
    step(1, 1, '0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, '0, 1, 0, 0);
    check("fill_full", 32'(stack_full), 1);
    step(1, 0, '0, 1, 0, 0);
    check("ovf_set", 32'(stack_ovf), 1);
    check("ovf_lvl", 32'(stack_level), 16);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, '0, 0, 1, 0);
      check("drain_sa", 32'(stack_addr), 32'(16 - i));
    end
    check("drain_empty", 32'(stack_empty), 1);

    // underflow and clear priority
    step(0, 0, '0, 0, 0, 1);
    check("ovf_clr", 32'(stack_ovf), 0);
    step(0, 0, '0, 0, 1, 0);
    check("unf_sa",  32'(stack_addr), 0);
    check("unf_set", 32'(stack_unf), 1);
    step(0, 0, '0, 0, 1, 1);
    check("unf_set_wins", 32'(stack_unf), 1);
    step(0, 0, '0, 0, 0, 1);
    check("unf_clr", 32'(stack_unf), 0);

    // simultaneous push/pop, then reset during a push
    step(1, 1, 11'h040, 0, 0, 0);
    step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 1, 0, 0);
    step(0, 0, '0, 0, 1, 0);
    step(0, 0, '0, 1, 0, 0);
    check("pre_both_lvl", 32'(stack_level), 2);
    step(1, 0, '0, 1, 1, 0);
    check("both_lvl", 32'(stack_level), 3);
    check("both_sa",  32'(stack_addr), 32'h042);
    @(negedge clk);
    ldpc = 1; selpc = 1; naddress = 11'h3AA; wr_en = 1; rd_en = 0; clr_err = 0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_lvl", 32'(stack_level), 0);
    check("async_rst_pc",  32'(pc_addr), 0);
    @(posedge clk);
    #1;
    check("rst_hold_lvl", 32'(stack_level), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
    step(0, 0, '0, 0, 0, 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit l, s, w, r, c;
      l = bit'($urandom_range(0, 1));
      s = bit'($urandom_range(0, 3) == 0);
      w = bit'($urandom_range(0, 2) == 0);
      r = bit'($urandom_range(0, 2) == 0);
      c = bit'($urandom_range(0, 7) == 0);
      step(l, s, AW'($urandom_range(0, 2047)), w, r, c);
    end

    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
